mux_n_ne_1_reg: RTL and testbench
=================================

Name: mux_n_ne_1_reg

Overview:
- Parametrised, registered N-to-1 datapath multiplexer for the 24-bit CPU; the next generation of the fixed 6-to-1 combinational selector.
- Adds a one-deep valid/ready output stage and a second selection mode, auto-scan, which walks the channels in round-robin order.
- Flags out-of-range selects instead of aliasing them onto a live channel.
- Sits between register-file/ALU result sources and the writeback bus.

Parameters:
- WIDTH, 24, data width per channel.
- NUM_INPUTS, 6, number of channels; legal range 2..2**SEL_W.
- SEL_W, 3, select width.

Ports:
- Clock  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset.
- Hyrjet  input  NUM_INPUTS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
- S  input  SEL_W  channel select, used when Mode=0.
- Mode  input  1  0 = explicit select; 1 = auto-scan.
- InValid  input  1  upstream offers data this cycle.
- InReady  output  1  block can accept this cycle.
- Dalja  output  WIDTH  registered selected data.
- Kanali  output  SEL_W  index of the channel held in Dalja.
- OutValid  output  1  Dalja/Kanali are valid.
- OutReady  input  1  downstream accepts this cycle.
- SelError  output  1  sticky out-of-range select flag.
- ClrError  input  1  synchronous clear of SelError.

Behaviour:
- Reset (Reset_n=0, asynchronous): Dalja=0, Kanali=0, OutValid=0, SelError=0, scan pointer=0. Reset has effect immediately and is independent of Clock.
- Reset mid-operation: any held output is discarded; OutValid drops at once. The first cycle after release is the idle state.
- InReady = !OutValid || OutReady. This is combinational and is the only combinational path from OutReady.
- Accept: a transfer is accepted when InValid && InReady at a rising edge.
- On accept:
  - Dalja <= channel[idx]; Kanali <= idx; OutValid <= 1.
  - idx = S when Mode=0; idx = scan pointer when Mode=1.
  - Latency is one cycle from accept to OutValid.
- Drain: OutValid && OutReady with no new accept makes OutValid <= 0. Dalja and Kanali keep their last value.
- Hold: OutValid=1 and OutReady=0 freezes Dalja, Kanali and OutValid; the input is stalled (InReady=0).
- Back-to-back: accept and drain in the same cycle give full throughput, one transfer per clock.
- Out-of-range select (Mode=0, accept, S >= NUM_INPUTS):
  - Dalja <= 0, Kanali <= S, OutValid <= 1 (the beat is still delivered).
  - SelError <= 1, and it stays set until ClrError.
  - If ClrError and a new error occur in the same cycle, set wins.
- Scan pointer (Mode=1 only):
  - Advances by 1 on each accept.
  - Wraps from NUM_INPUTS-1 to 0; it never takes an out-of-range value.
  - Holds when there is no accept.
  - Holds its value while Mode=0.
  - Is not reset by a Mode change; continuing the scan resumes where it left off.
- Mode switching: Mode is sampled only at the accept edge, so a Mode change while stalled affects the next accept only.
- Hyrjet and S are sampled only at the accept edge; changes while stalled have no effect on Dalja.
- No X propagation: unused select codes never read outside Hyrjet.

Test Plan:
- Reset/basic: assert Reset_n=0 mid-cycle → all outputs 0 immediately. Release, Mode=0, S=2, channel2=24'hABCDEF, InValid=1, OutReady=1 → next cycle Dalja=ABCDEF, Kanali=2, OutValid=1.
- Backpressure: OutReady=0 after capture of channel1=24'h000111; change S=4 and Hyrjet for 3 cycles → Dalja stays 000111, InReady=0. Raise OutReady → drain, then the channel4 value is captured on the same edge (throughput 1/clk).
- Out-of-range: NUM_INPUTS=6, S=3'b110 and 3'b111 → Dalja=0, Kanali=6 then 7, SelError=1 and it persists. ClrError pulse → SelError=0. ClrError in the same cycle as a new bad S → SelError stays 1.
- Auto-scan: Mode=1, InValid=1, OutReady=1 for 8 cycles, channel k = k*24'h10 → Kanali sequence 0,1,2,3,4,5,0,1; Dalja matches each channel.
- Scan hold/resume: Mode=1 for 3 accepts (pointer=3), switch to Mode=0 S=5 for 2 accepts, back to Mode=1 → next Kanali=3. InValid=0 gaps do not advance the pointer.
- Parametrisation: WIDTH=8, NUM_INPUTS=8, SEL_W=3 → all 8 selects valid, SelError never asserts, scan wraps 7→0.

Source files
------------

// File: rtl/mux_n_ne_1_reg.sv
// -----------------------------------------------------------------------------
// mux_n_ne_1_reg
//   Registered N-to-1 datapath multiplexer with a one-deep valid/ready output
//   stage. Two selection modes:
//     Mode=0 : explicit select, channel index taken from S
//     Mode=1 : auto-scan, channel index taken from an internal round-robin
//              pointer that advances on every accepted beat
//   Out-of-range explicit selects still deliver a beat (data forced to zero,
//   Kanali carries the offending code) and raise a sticky SelError.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset_n   in   asynchronous active-low reset
//   Hyrjet    in   NUM_INPUTS*WIDTH flattened channels, channel k at [k*WIDTH +: WIDTH]
//   S         in   SEL_W explicit channel select (Mode=0)
//   Mode      in   0 = explicit select, 1 = auto-scan
//   InValid   in   upstream offers data
//   InReady   out  block can accept this cycle (combinational)
//   Dalja     out  WIDTH registered selected data
//   Kanali    out  SEL_W index of the channel held in Dalja
//   OutValid  out  Dalja/Kanali valid
//   OutReady  in   downstream accepts
//   SelError  out  sticky out-of-range select flag
//   ClrError  in   synchronous clear of SelError (a new error in the same
//                  cycle wins)
// -----------------------------------------------------------------------------
module mux_n_ne_1_reg #(
    parameter int WIDTH      = 24,
    parameter int NUM_INPUTS = 6,
    parameter int SEL_W      = 3
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] Hyrjet,
    input  logic [SEL_W-1:0]            S,
    input  logic                        Mode,
    input  logic                        InValid,
    output logic                        InReady,
    output logic [WIDTH-1:0]            Dalja,
    output logic [SEL_W-1:0]            Kanali,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic                        SelError,
    input  logic                        ClrError
);

    // One extra bit so NUM_INPUTS == 2**SEL_W is representable.
    localparam logic [SEL_W:0]   NUM_L    = (SEL_W+1)'(NUM_INPUTS);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

    logic [WIDTH-1:0] dalja_q,     dalja_d;
    logic [SEL_W-1:0] kanali_q,    kanali_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q,   sel_err_d;
    logic [SEL_W-1:0] scan_ptr_q,  scan_ptr_d;

    logic             accept;
    logic             in_range;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;

    // Skid-free one-deep stage: the slot is free when empty or draining now.
    assign InReady  = !out_valid_q || OutReady;
    assign accept   = InValid && InReady;

    assign idx      = Mode ? scan_ptr_q : S;
    assign in_range = {1'b0, idx} < NUM_L;

    // Compare-and-select over the legal channels only. Codes at or above
    // NUM_INPUTS match nothing and leave sel_data at zero, so no slice
    // outside Hyrjet is ever addressed.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = Hyrjet[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        dalja_d     = dalja_q;
        kanali_d    = kanali_q;
        out_valid_d = out_valid_q;
        sel_err_d   = sel_err_q;
        scan_ptr_d  = scan_ptr_q;

        if (accept) begin
            dalja_d     = sel_data;
            kanali_d    = idx;
            out_valid_d = 1'b1;
        end else if (OutReady) begin
            // Drain only; data and channel index keep their last value.
            out_valid_d = 1'b0;
        end

        // The pointer only moves on scan-mode accepts, so it survives
        // excursions into explicit mode and stalls untouched.
        if (accept && Mode) begin
            scan_ptr_d = (scan_ptr_q == LAST_IDX) ? '0 : scan_ptr_q + 1'b1;
        end

        // Set has priority over clear.
        if (accept && !Mode && !in_range) begin
            sel_err_d = 1'b1;
        end else if (ClrError) begin
            sel_err_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            dalja_q     <= '0;
            kanali_q    <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_ptr_q  <= '0;
        end else begin
            dalja_q     <= dalja_d;
            kanali_q    <= kanali_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            scan_ptr_q  <= scan_ptr_d;
        end
    end

    assign Dalja    = dalja_q;
    assign Kanali   = kanali_q;
    assign OutValid = out_valid_q;
    assign SelError = sel_err_q;

endmodule

// File: tb/tb_mux_n_ne_1_reg.sv
// Scoreboard bench for mux_n_ne_1_reg. Two instances share the control
// stimulus: A is the default 24-bit / 6-channel build, B is 8-bit / 8-channel.
module tb_mux_n_ne_1_reg;
    localparam int NA = 6, WA = 24, NB = 8, WB = 8;

    logic Clock = 1'b0;
    logic rst_n;
    always #5 Clock = ~Clock;

    logic [2:0] s;
    logic       mode, in_valid, out_ready, clr;
    logic [WA-1:0] chA [NA];
    logic [WB-1:0] chB [NB];
    logic [NA*WA-1:0] hyrA;
    logic [NB*WB-1:0] hyrB;

    always_comb begin
        hyrA = '0;
        for (int k = 0; k < NA; k++) hyrA[k*WA +: WA] = chA[k];
    end
    always_comb begin
        hyrB = '0;
        for (int k = 0; k < NB; k++) hyrB[k*WB +: WB] = chB[k];
    end

    logic          a_ir, a_ov, a_se, b_ir, b_ov, b_se;
    logic [WA-1:0] a_d;
    logic [WB-1:0] b_d;
    logic [2:0]    a_k, b_k;

    mux_n_ne_1_reg #(.WIDTH(WA), .NUM_INPUTS(NA), .SEL_W(3)) dut_a (
        .Clock(Clock), .Reset_n(rst_n), .Hyrjet(hyrA), .S(s), .Mode(mode),
        .InValid(in_valid), .InReady(a_ir), .Dalja(a_d), .Kanali(a_k),
        .OutValid(a_ov), .OutReady(out_ready), .SelError(a_se), .ClrError(clr)
    );

    mux_n_ne_1_reg #(.WIDTH(WB), .NUM_INPUTS(NB), .SEL_W(3)) dut_b (
        .Clock(Clock), .Reset_n(rst_n), .Hyrjet(hyrB), .S(s), .Mode(mode),
        .InValid(in_valid), .InReady(b_ir), .Dalja(b_d), .Kanali(b_k),
        .OutValid(b_ov), .OutReady(out_ready), .SelError(b_se), .ClrError(clr)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  k;
    } beat_t;

    beat_t qa[$], qb[$];
    bit    mva, mvb, ea, eb;
    int    pa, pb, idx_m;
    bit    acc_m;
    beat_t bt;

    always @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete(); qb.delete();
            mva = 0; mvb = 0; ea = 0; eb = 0; pa = 0; pb = 0;
        end else begin
            // instance A
            acc_m = in_valid && (!mva || out_ready);
            if (acc_m) begin
                idx_m = mode ? pa : int'(s);
                bt.k  = 3'(idx_m);
                if (idx_m < NA) bt.d = chA[idx_m];
                else            bt.d = 24'h0;
                qa.push_back(bt);
                mva = 1;
                if (mode) pa = (pa + 1) % NA;
            end else if (out_ready) begin
                mva = 0;
            end
            if (acc_m && !mode && int'(s) >= NA) ea = 1;
            else if (clr)                         ea = 0;

            // instance B
            acc_m = in_valid && (!mvb || out_ready);
            if (acc_m) begin
                idx_m = mode ? pb : int'(s);
                bt.k  = 3'(idx_m);
                if (idx_m < NB) bt.d = {16'h0, chB[idx_m]};
                else            bt.d = 24'h0;
                qb.push_back(bt);
                mvb = 1;
                if (mode) pb = (pb + 1) % NB;
            end else if (out_ready) begin
                mvb = 0;
            end
            if (acc_m && !mode && int'(s) >= NB) eb = 1;
            else if (clr)                         eb = 0;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge Clock) begin
        if (rst_n) begin
            chk("a_valid",   32'(a_ov), 32'(mva));
            chk("a_inready", 32'(a_ir), 32'(!mva || out_ready));
            chk("a_selerr",  32'(a_se), 32'(ea));
            if (a_ov) begin
                chk("a_qdepth", 32'(qa.size()), 32'd1);
                if (qa.size() > 0) begin
                    chk("a_data", 32'(a_d), 32'(qa[0].d));
                    chk("a_chan", 32'(a_k), 32'(qa[0].k));
                    if (out_ready) void'(qa.pop_front());
                end
            end
            chk("b_valid",   32'(b_ov), 32'(mvb));
            chk("b_inready", 32'(b_ir), 32'(!mvb || out_ready));
            chk("b_selerr",  32'(b_se), 32'(eb));
            if (b_ov) begin
                chk("b_qdepth", 32'(qb.size()), 32'd1);
                if (qb.size() > 0) begin
                    chk("b_data", 32'(b_d), 32'(qb[0].d));
                    chk("b_chan", 32'(b_k), 32'(qb[0].k));
                    if (out_ready) void'(qb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input bit m, input logic [2:0] sel,
                         input bit ordy, input bit c);
        @(posedge Clock);
        #2;
        in_valid = v; mode = m; s = sel; out_ready = ordy; clr = c;
    endtask

    task automatic idle_cyc();
        drive(1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; mode = 1'b0; s = 3'd0; out_ready = 1'b0; clr = 1'b0;
        for (int k = 0; k < NA; k++) chA[k] = 24'($urandom);
        for (int k = 0; k < NB; k++) chB[k] = 8'($urandom);
        repeat (3) @(posedge Clock);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_a_valid", 32'(a_ov), 32'd0);
        chk("rst_a_data",  32'(a_d),  32'd0);
        chk("rst_a_chan",  32'(a_k),  32'd0);
        chk("rst_a_err",   32'(a_se), 32'd0);
        chk("rst_b_valid", 32'(b_ov), 32'd0);

        // basic capture
        chA[2] = 24'hABCDEF;
        drive(1, 0, 3'd2, 1, 0);
        idle_cyc();

        // backpressure: capture ch1, then stall while S/Hyrjet churn
        chA[1] = 24'h000111;
        drive(1, 0, 3'd1, 1, 0);
        drive(1, 0, 3'd4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chA[4] = 24'($urandom); chA[1] = 24'($urandom); chB[4] = 8'($urandom);
            drive(1, 0, 3'd4, 0, 0);
        end
        drive(1, 0, 3'd4, 1, 0);
        idle_cyc();

        // out-of-range selects, sticky flag, clear, set-beats-clear
        drive(1, 0, 3'd6, 1, 0);
        drive(1, 0, 3'd7, 1, 0);
        idle_cyc();
        idle_cyc();
        drive(0, 0, 3'd0, 1, 1);
        idle_cyc();
        drive(1, 0, 3'd6, 1, 1);
        idle_cyc();
        drive(0, 0, 3'd0, 1, 1);
        idle_cyc();

        // auto-scan over 8 beats
        for (int k = 0; k < NA; k++) chA[k] = 24'(k * 16);
        for (int k = 0; k < NB; k++) chB[k] = 8'(k * 16);
        repeat (8) drive(1, 1, 3'd0, 1, 0);
        idle_cyc();

        // reset mid-operation while holding an erroring beat
        drive(1, 0, 3'd7, 0, 0);
        drive(1, 0, 3'd3, 0, 0);
        @(negedge Clock);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_a_valid", 32'(a_ov), 32'd0);
        chk("mid_rst_a_data",  32'(a_d),  32'd0);
        chk("mid_rst_a_chan",  32'(a_k),  32'd0);
        chk("mid_rst_a_err",   32'(a_se), 32'd0);
        chk("mid_rst_b_valid", 32'(b_ov), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge Clock);
        #2 rst_n = 1'b1;

        // scan hold/resume around explicit beats and gaps
        repeat (3) drive(1, 1, 3'd0, 1, 0);
        repeat (2) drive(1, 0, 3'd5, 1, 0);
        drive(0, 1, 3'd0, 1, 0);
        drive(0, 1, 3'd0, 0, 0);
        drive(1, 1, 3'd0, 1, 0);
        idle_cyc();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < NA; k++) if ($urandom_range(1) == 1) chA[k] = 24'($urandom);
            for (int k = 0; k < NB; k++) if ($urandom_range(1) == 1) chB[k] = 8'($urandom);
            drive($urandom_range(3) != 0, $urandom_range(1) == 1, 3'($urandom_range(7)),
                  $urandom_range(3) != 0, $urandom_range(9) == 0);
        end

        repeat (4) idle_cyc();
        @(negedge Clock);
        #1;
        chk("a_drained", 32'(qa.size()), 32'd0);
        chk("b_drained", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
